// File: rtl/regfile_writeback_unit_pkg.sv
// Shared constants and record types for the regfile write-back path.
package regfile_writeback_unit_pkg;

    localparam int unsigned NUM_PREGS = 64;
    localparam int unsigned PREG_W    = 7;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_IN    = 3;
    localparam int unsigned NUM_WR    = 2;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PREG_W-1:0] prd;
        logic [DATA_W-1:0] data;
    } wbEntryStruct;

    typedef struct packed {
        logic              en;
        logic [PREG_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } regReqStruct;

endpackage

// File: rtl/regfile_writeback_unit_if.sv
// Completion-in / regfile-write-out bundle; slave is the write-back unit side.
interface regfile_writeback_unit_if;
    import regfile_writeback_unit_pkg::*;

    logic                     flush;
    logic [NUM_IN-1:0]        cmp_valid;
    logic                     cmp_ready;
    logic [NUM_IN*PREG_W-1:0] cmp_prd;
    logic [NUM_IN*DATA_W-1:0] cmp_data;
    logic                     drain_en;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*PREG_W-1:0] wr_rd;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_WR-1:0]        rdy_valid;
    logic [NUM_WR*PREG_W-1:0] rdy_prd;

    modport master (
        output flush, cmp_valid, cmp_prd, cmp_data, drain_en,
        input  cmp_ready, wr_en, wr_rd, wr_data, rdy_valid, rdy_prd
    );

    modport slave (
        input  flush, cmp_valid, cmp_prd, cmp_data, drain_en,
        output cmp_ready, wr_en, wr_rd, wr_data, rdy_valid, rdy_prd
    );

endinterface

// File: rtl/regfile_writeback_unit_wb_fifo_ptrs.sv
// Head/tail/count bookkeeping for the write-back FIFO; pointers wrap modulo DEPTH.
module wb_fifo_ptrs
    import regfile_writeback_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic [CNT_W-1:0] enq_cnt_i,
    input  logic [CNT_W-1:0] pop_cnt_i,
    output logic [PTR_W-1:0] head_o,
    output logic [PTR_W-1:0] tail_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ready_o
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q + PTR_W'(pop_cnt_i);
        tail_d  = tail_q + PTR_W'(enq_cnt_i);
        count_d = count_q + enq_cnt_i - pop_cnt_i;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Only the registered count is used, so freshly drained slots are not reusable this cycle.
    assign ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(NUM_IN);

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;

endmodule

// File: rtl/regfile_writeback_unit.sv
// In-order completion buffer that drains onto the regfile write ports, dropping preg 0
// and holding back a second write to the same preg within one cycle.
module regfile_writeback_unit
    import regfile_writeback_unit_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    regfile_writeback_unit_if.slave        wb
);

    wbEntryStruct     mem_q [DEPTH];
    wbEntryStruct     lane_ent [NUM_IN];
    logic [PTR_W-1:0] lane_idx [NUM_IN];
    logic [NUM_IN-1:0] lane_we;
    wbEntryStruct     cand [NUM_WR];
    regReqStruct      req [NUM_WR];

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count, enq_cnt, pop_cnt;
    logic             ready;
    logic             stop;

    wb_fifo_ptrs u_ptrs (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (wb.flush),
        .enq_cnt_i (enq_cnt),
        .pop_cnt_i (pop_cnt),
        .head_o    (head),
        .tail_o    (tail),
        .count_o   (count),
        .ready_o   (ready)
    );

    // Valid lanes pack contiguously from tail in lane order.
    always_comb begin
        enq_cnt = '0;
        lane_we = '0;
        for (int unsigned l = 0; l < NUM_IN; l++) begin
            lane_ent[l].prd  = wb.cmp_prd[l*PREG_W +: PREG_W];
            lane_ent[l].data = wb.cmp_data[l*DATA_W +: DATA_W];
            lane_idx[l]      = tail + PTR_W'(enq_cnt);
            if (ready && !wb.flush && wb.cmp_valid[l]) begin
                lane_we[l] = 1'b1;
                enq_cnt    = enq_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < NUM_IN; l++) begin
            if (lane_we[l]) begin
                mem_q[lane_idx[l]] <= lane_ent[l];
            end
        end
    end

    // Eligibility is a prefix: once a candidate is out of range or repeats an
    // earlier written preg, it and every later candidate wait for a later cycle.
    always_comb begin
        pop_cnt = '0;
        stop    = !wb.drain_en || wb.flush;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            cand[j]     = mem_q[head + PTR_W'(j)];
            req[j]      = '0;
            req[j].rd   = cand[j].prd;
            req[j].data = cand[j].data;
            if (CNT_W'(j) >= count) begin
                stop = 1'b1;
            end
            for (int unsigned k = 0; k < j; k++) begin
                if (req[k].en && (req[k].rd == cand[j].prd)) begin
                    stop = 1'b1;
                end
            end
            if (!stop) begin
                pop_cnt   = pop_cnt + CNT_W'(1);
                req[j].en = (cand[j].prd != '0);
            end
        end
    end

    always_comb begin
        wb.wr_en   = '0;
        wb.wr_rd   = '0;
        wb.wr_data = '0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            wb.wr_en[j]                    = req[j].en;
            wb.wr_rd[j*PREG_W +: PREG_W]   = req[j].rd;
            wb.wr_data[j*DATA_W +: DATA_W] = req[j].data;
        end
    end

    assign wb.cmp_ready = ready;
    assign wb.rdy_valid = wb.wr_en;
    assign wb.rdy_prd   = wb.wr_rd;

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Directed bench for regfile_writeback_unit with a queue-based reference model.
module tb_regfile_writeback_unit;
    import regfile_writeback_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_writeback_unit_if bus ();

    regfile_writeback_unit dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    typedef struct {
        logic [PREG_W-1:0] prd;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t        q[$];
    ent_t        wlog[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned exp_pop  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: outputs derived from the pending-result queue each cycle.
    always @(negedge clk) begin : model_cmp
        logic [PREG_W-1:0] seen[$];
        logic [NUM_WR-1:0] een;
        bit                stop, dup;
        ent_t              e;
        exp_pop = 0;
        if (!reset) begin
            chk("cmp_ready", 64'(bus.cmp_ready), ((DEPTH - q.size()) >= NUM_IN) ? 64'd1 : 64'd0);
            een = '0;
            seen.delete();
            stop = !bus.drain_en || bus.flush;
            for (int i = 0; i < NUM_WR; i++) begin
                if (stop || i >= q.size()) break;
                dup = 0;
                foreach (seen[s]) if (seen[s] == q[i].prd) dup = 1;
                if (dup) break;
                exp_pop++;
                if (q[i].prd != 0) begin
                    een[i] = 1'b1;
                    seen.push_back(q[i].prd);
                    chk("wr_rd",   64'(bus.wr_rd[i*PREG_W +: PREG_W]),   64'(q[i].prd));
                    chk("wr_data", 64'(bus.wr_data[i*DATA_W +: DATA_W]), 64'(q[i].data));
                    chk("rdy_prd", 64'(bus.rdy_prd[i*PREG_W +: PREG_W]), 64'(q[i].prd));
                end
            end
            chk("wr_en",     64'(bus.wr_en),     64'(een));
            chk("rdy_valid", 64'(bus.rdy_valid), 64'(een));
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j]) begin
                    e.prd  = bus.wr_rd[j*PREG_W +: PREG_W];
                    e.data = bus.wr_data[j*DATA_W +: DATA_W];
                    wlog.push_back(e);
                end
            end
        end
    end

    always @(posedge clk) begin : model_upd
        bit   acc;
        ent_t e;
        if (reset || bus.flush) begin
            q.delete();
        end else begin
            acc = (DEPTH - q.size()) >= NUM_IN;
            repeat (exp_pop) void'(q.pop_front());
            if (acc) begin
                for (int l = 0; l < NUM_IN; l++) begin
                    if (bus.cmp_valid[l]) begin
                        e.prd  = bus.cmp_prd[l*PREG_W +: PREG_W];
                        e.data = bus.cmp_data[l*DATA_W +: DATA_W];
                        q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [2:0] v,
                         input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                         input logic de, input logic fl);
        bus.cmp_valid = v;
        bus.cmp_prd   = {p2, p1, p0};
        bus.cmp_data  = {d2, d1, d0};
        bus.drain_en  = de;
        bus.flush     = fl;
    endtask

    task automatic idle(input logic de);
        drive(3'b000, 7'd0, 7'd0, 7'd0, 32'd0, 32'd0, 32'd0, de, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string name, input int idx, input int prd, input int data);
        if (idx < wlog.size()) begin
            chk({name, "_prd"},  64'(wlog[idx].prd),  64'(prd));
            chk({name, "_data"}, 64'(wlog[idx].data), 64'(data));
        end else begin
            chk({name, "_missing"}, 64'(wlog.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_fail++;
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        int          n;
        logic [2:0]  v;
        logic [6:0]  p [3];
        logic [31:0] d [3];
        logic        r;

        reset = 1'b1;
        idle(1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready",     64'(bus.cmp_ready), 64'd1);
        chk("rst_wr_en",     64'(bus.wr_en),     64'd0);
        chk("rst_rdy_valid", 64'(bus.rdy_valid), 64'd0);
        step();

        // Single entry
        wlog.delete();
        drive(3'b001, 7'd5, 7'd0, 7'd0, 32'hDEADBEEF, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        step();
        idle(1'b1);
        @(negedge clk);
        chk("t1_wr_en",    64'(bus.wr_en),         64'h1);
        chk("t1_wr_rd0",   64'(bus.wr_rd[6:0]),    64'd5);
        chk("t1_wr_data0", 64'(bus.wr_data[31:0]), 64'hDEADBEEF);
        chk("t1_rdy_prd0", 64'(bus.rdy_prd[6:0]),  64'd5);
        step();
        @(negedge clk);
        chk("t1_after_wr_en", 64'(bus.wr_en),     64'd0);
        chk("t1_after_ready", 64'(bus.cmp_ready), 64'd1);
        step();

        // Same-preg conflict
        drive(3'b011, 7'd9, 7'd9, 7'd0, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        step();
        idle(1'b1);
        @(negedge clk);
        chk("t2_c0_wr_en", 64'(bus.wr_en),         64'h1);
        chk("t2_c0_rd",    64'(bus.wr_rd[6:0]),    64'd9);
        chk("t2_c0_data",  64'(bus.wr_data[31:0]), 64'h1);
        step();
        @(negedge clk);
        chk("t2_c1_wr_en", 64'(bus.wr_en),         64'h1);
        chk("t2_c1_rd",    64'(bus.wr_rd[6:0]),    64'd9);
        chk("t2_c1_data",  64'(bus.wr_data[31:0]), 64'h2);
        step();
        @(negedge clk);
        chk("t2_done_wr_en", 64'(bus.wr_en), 64'd0);
        step();

        // Preg 0 dropped but consumes its slot
        drive(3'b011, 7'd0, 7'd3, 7'd0, 32'hAA, 32'hBB, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        step();
        idle(1'b1);
        @(negedge clk);
        chk("t3_wr_en",  64'(bus.wr_en),          64'h2);
        chk("t3_rd1",    64'(bus.wr_rd[13:7]),    64'd3);
        chk("t3_data1",  64'(bus.wr_data[63:32]), 64'hBB);
        step();
        @(negedge clk);
        chk("t3_done_wr_en", 64'(bus.wr_en), 64'd0);
        step();

        // Backpressure
        wlog.delete();
        drive(3'b111, 7'd10, 7'd11, 7'd12, 32'h100, 32'h101, 32'h102, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_ready_c0", 64'(bus.cmp_ready), 64'd1);
        step();
        drive(3'b111, 7'd13, 7'd14, 7'd15, 32'h103, 32'h104, 32'h105, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_ready_c3", 64'(bus.cmp_ready), 64'd1);
        step();
        drive(3'b111, 7'd16, 7'd17, 7'd18, 32'h106, 32'h107, 32'h108, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_ready_c6", 64'(bus.cmp_ready), 64'd0);
        chk("t4_hold_wr_en", 64'(bus.wr_en), 64'd0);
        step();
        drive(3'b111, 7'd16, 7'd17, 7'd18, 32'h106, 32'h107, 32'h108, 1'b1, 1'b0);
        @(negedge clk);
        chk("t4_ready_drain6", 64'(bus.cmp_ready), 64'd0);
        chk("t4_drain_wr_en",  64'(bus.wr_en),     64'h3);
        step();
        @(negedge clk);
        chk("t4_ready_c4", 64'(bus.cmp_ready), 64'd1);
        step();
        idle(1'b1);
        repeat (4) step();
        chk("t4_log_size", 64'(wlog.size()), 64'd9);
        for (int k = 0; k < 9; k++) chk_log("t4_order", k, 10 + k, 'h100 + k);

        // Wrap-around with toggling drain
        wlog.delete();
        idx = 0;
        for (int c = 0; c < 200 && idx < 20; c++) begin
            n = (c % 3) + 1;
            if (n > 20 - idx) n = 20 - idx;
            for (int l = 0; l < 3; l++) begin
                p[l] = 7'd0;
                d[l] = 32'd0;
            end
            case (n)
                1: begin
                    v = 3'b010;
                    p[1] = 7'(20 + idx); d[1] = 32'(32'hA000 + idx);
                end
                2: begin
                    v = 3'b101;
                    p[0] = 7'(20 + idx);     d[0] = 32'(32'hA000 + idx);
                    p[2] = 7'(21 + idx);     d[2] = 32'(32'hA001 + idx);
                end
                default: begin
                    v = 3'b111;
                    for (int l = 0; l < 3; l++) begin
                        p[l] = 7'(20 + idx + l);
                        d[l] = 32'(32'hA000 + idx + l);
                    end
                end
            endcase
            drive(v, p[0], p[1], p[2], d[0], d[1], d[2], logic'((c / 2) % 2), 1'b0);
            @(negedge clk);
            r = bus.cmp_ready;
            step();
            if (r) idx += n;
        end
        chk("t5_all_sent", 64'(idx), 64'd20);
        idle(1'b1);
        repeat (12) step();
        chk("t5_log_size", 64'(wlog.size()), 64'd20);
        for (int k = 0; k < 20; k++) chk_log("t5_order", k, 20 + k, 'hA000 + k);

        // Flush mid-operation
        wlog.delete();
        drive(3'b111, 7'd50, 7'd51, 7'd52, 32'h50, 32'h51, 32'h52, 1'b0, 1'b0);
        step();
        drive(3'b011, 7'd53, 7'd54, 7'd0, 32'h53, 32'h54, 32'h0, 1'b0, 1'b0);
        step();
        drive(3'b111, 7'd55, 7'd56, 7'd57, 32'h55, 32'h56, 32'h57, 1'b1, 1'b1);
        @(negedge clk);
        chk("t6_flush_wr_en", 64'(bus.wr_en), 64'd0);
        step();
        idle(1'b1);
        @(negedge clk);
        chk("t6_post_wr_en", 64'(bus.wr_en),     64'd0);
        chk("t6_post_ready", 64'(bus.cmp_ready), 64'd1);
        step();
        repeat (3) step();
        chk("t6_log_size", 64'(wlog.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
